// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit:
// funct3 encodings, trap cause codes, FSM states.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_align_check.sv
// Combinational funct3 legality and natural
// alignment check for one load/store.
module lsu_align_check
    import load_store_unit_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] funct3,
    input  logic       is_store,
    output logic       misaligned,
    output logic       illegal
);

    logic half;
    logic word;

    // Legality differs for loads and stores
    always_comb begin
        illegal = 1'b1;
        if (is_store) begin
            unique case (funct3)
                F3_SB, F3_SH, F3_SW: illegal = 1'b0;
                default:             illegal = 1'b1;
            endcase
        end else begin
            unique case (funct3)
                F3_LB, F3_LH, F3_LW,
                F3_LBU, F3_LHU:      illegal = 1'b0;
                default:             illegal = 1'b1;
            endcase
        end
    end

    assign half = (funct3[1:0] == 2'b01);
    assign word = (funct3[1:0] == 2'b10);

    // Illegal ops report cause 2, so mask misalignment
    assign misaligned = ~illegal &
                        ((half & addr[0]) |
                         (word & (addr != 2'b00)));

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store,
// drives req until ack/timeout, returns data or trap.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_lsu_valid,
    input  logic            i_lsu_is_store,
    input  logic [XLEN-1:0] i_lsu_addr,
    input  logic [XLEN-1:0] i_lsu_wdata,
    input  logic [2:0]      i_lsu_funct3,
    input  logic [4:0]      i_lsu_rd,
    input  logic            i_flush,
    output logic            o_lsu_busy,
    output logic            or_lsu_done,
    output logic [XLEN-1:0] or_lsu_rdata,
    output logic [4:0]      or_lsu_rd,
    output logic            or_lsu_rd_we,
    output logic            or_trap,
    output logic [3:0]      or_trap_cause,
    output logic [XLEN-1:0] or_trap_val,
    output logic            or_mem_req,
    output logic [XLEN-1:0] or_mem_addr,
    output logic [XLEN-1:0] or_mem_data,
    output logic [2:0]      or_mem_funct3,
    output logic            or_mem_read_write,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_data
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q;
    lsu_state_e      state_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] tval_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic [3:0]      cause_q;
    logic [7:0]      cnt_q;
    logic            ld_q;
    logic            ok_q;
    logic            trap_q;
    logic            flushed_q;

    logic misaligned;
    logic illegal;
    logic accept;
    logic in_req;
    logic abort;
    logic timeout;
    logic pulse_en;

    lsu_align_check u_align (
        .addr       (i_lsu_addr[1:0]),
        .funct3     (i_lsu_funct3),
        .is_store   (i_lsu_is_store),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign accept  = (state_q == LSU_IDLE) &
                     i_lsu_valid & ~i_flush;
    assign in_req  = (state_q == LSU_REQ);
    assign abort   = in_req & i_flush & ld_q;
    assign timeout = in_req & ~i_mem_ack &
                     (cnt_q == TMO_LAST);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= LSU_IDLE;
        else          state_q <= state_d;
    end

    // Next state: checks fail straight to DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LSU_IDLE: begin
                if (accept)
                    state_d = (illegal | misaligned) ?
                              LSU_DONE : LSU_REQ;
            end
            LSU_REQ: begin
                if (abort)
                    state_d = LSU_IDLE;
                else if (i_mem_ack | timeout)
                    state_d = LSU_DONE;
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // Latch the op on accept; track outcome in REQ
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            tval_q    <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            cause_q   <= '0;
            cnt_q     <= '0;
            ld_q      <= 1'b0;
            ok_q      <= 1'b0;
            trap_q    <= 1'b0;
            flushed_q <= 1'b0;
        end else if (accept) begin
            addr_q    <= i_lsu_addr;
            wdata_q   <= i_lsu_wdata;
            f3_q      <= i_lsu_funct3;
            rd_q      <= i_lsu_rd;
            ld_q      <= ~i_lsu_is_store;
            ok_q      <= 1'b0;
            trap_q    <= illegal | misaligned;
            flushed_q <= 1'b0;
            cnt_q     <= '0;
            if (illegal) begin
                cause_q <= CAUSE_ILLEGAL;
                tval_q  <= '0;
            end else begin
                cause_q <= i_lsu_is_store ?
                           CAUSE_STORE_MISALIGNED :
                           CAUSE_LOAD_MISALIGNED;
                tval_q  <= i_lsu_addr;
            end
        end else if (in_req) begin
            cnt_q <= cnt_q + 8'd1;
            // A flushed store still runs to completion
            if (i_flush) flushed_q <= 1'b1;
            if (!abort) begin
                if (i_mem_ack) begin
                    ok_q <= 1'b1;
                    if (ld_q) rdata_q <= i_mem_data;
                end else if (timeout) begin
                    trap_q  <= 1'b1;
                    cause_q <= ld_q ? CAUSE_LOAD_FAULT :
                                      CAUSE_STORE_FAULT;
                    tval_q  <= addr_q;
                end
            end
        end
    end

    assign pulse_en = (state_q == LSU_DONE) &
                      ~i_flush & ~flushed_q;

    assign o_lsu_busy        = i_lsu_valid &
                               (state_q != LSU_DONE);
    assign or_lsu_done       = pulse_en & ok_q;
    assign or_lsu_rdata      = rdata_q;
    assign or_lsu_rd         = rd_q;
    assign or_lsu_rd_we      = or_lsu_done & ld_q &
                               (rd_q != 5'd0);
    assign or_trap           = pulse_en & trap_q;
    assign or_trap_cause     = or_trap ? cause_q : '0;
    assign or_trap_val       = or_trap ? tval_q : '0;
    assign or_mem_req        = in_req;
    assign or_mem_addr       = addr_q;
    assign or_mem_data       = wdata_q;
    assign or_mem_funct3     = f3_q;
    assign or_mem_read_write = in_req & ld_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory request/ack interface.
- Sits between the CPU execute/memory stage and data memory.
- Accepts one load or store per transaction, checks alignment and funct3 legality, and drives the memory request until ack or timeout.
- Returns load data with writeback control, or a trap (cause, mtval) to the Zicsr trap logic.

Parameters:
- XLEN, 32, data/address width (matches `XLEN).
- TIMEOUT_CYCLES, 16, REQ-state cycles without i_mem_ack before an access fault is raised (legal range 2..255).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_lsu_valid  in  1  pipeline presents a memory op; held until or_lsu_done or or_trap
- i_lsu_is_store  in  1  1=store, 0=load
- i_lsu_addr  in  XLEN  effective byte address
- i_lsu_wdata  in  XLEN  store data (low bytes used for SB/SH)
- i_lsu_funct3  in  3  RV32I load/store funct3
- i_lsu_rd  in  5  load destination register
- i_flush  in  1  pipeline flush
- o_lsu_busy  out  1  combinational stall, = i_lsu_valid & (state!=DONE)
- or_lsu_done  out  1  one-cycle pulse: op completed successfully
- or_lsu_rdata  out  XLEN  load result (already extended by memory)
- or_lsu_rd  out  5  destination register for the result
- or_lsu_rd_we  out  1  register write enable; pulses with done, 0 for stores and rd=0
- or_trap  out  1  one-cycle trap pulse
- or_trap_cause  out  4  mcause exception code
- or_trap_val  out  XLEN  mtval (faulting address, 0 for illegal)
- or_mem_req  out  1  memory request, high only in REQ
- or_mem_addr  out  XLEN  latched address
- or_mem_data  out  XLEN  latched store data
- or_mem_funct3  out  3  latched funct3
- or_mem_read_write  out  1  1=read (load), 0=write (store)
- i_mem_ack  in  1  memory acknowledge (may be combinational, same cycle as req)
- i_mem_data  in  XLEN  memory read data, valid while i_mem_ack

Behaviour:
- **Reset:**
  - All or_* outputs are 0 and the state is IDLE.
  - The timeout counter is 0.
  - Asserting reset mid-REQ drops or_mem_req immediately (asynchronous).
- **States:** IDLE, REQ, DONE.
- **IDLE:**
  - An op is accepted when i_lsu_valid=1 and i_flush=0. Accepting latches addr, wdata, funct3, rd, is_store and the check result.
  - Legal ops go to REQ.
  - An illegal or misaligned op goes to DONE with a trap pending and never asserts or_mem_req.
  - i_flush=1 blocks acceptance.
- **Legal funct3:**
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else: cause 2 (illegal instruction), mtval 0.
- **Misaligned access:**
  - Halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Cause 4 for a load, 6 for a store; mtval = addr.
- **REQ:**
  - or_mem_req=1 with latched addr/data/funct3 held stable.
  - The counter increments each cycle.
  - i_mem_ack=1: capture i_mem_data (loads), go to DONE with success; or_mem_req is low the next cycle.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: go to DONE with a trap, cause 5 (load) or 7 (store), mtval = addr.
  - Ack and timeout in the same cycle: ack wins.
- **DONE:**
  - One cycle; pulses exactly one of or_lsu_done / or_trap; then returns to IDLE unconditionally.
  - The op still presented on i_lsu_valid this cycle is not re-accepted.
  - o_lsu_busy=0 in DONE, so the pipeline advances.
- **Flush:**
  - In REQ, a load aborts: req drops, return to IDLE, no done/trap.
  - In REQ, a store is not cancellable: it completes, but or_lsu_done is suppressed.
  - In DONE, both pulses are suppressed.
- **Latency:** accept at N, or_mem_req at N+1, done/trap at N+2 with a combinational-ack memory. Misaligned/illegal ops trap at N+1.
- **Write enable:** or_lsu_rd_we = done & load & (rd!=0).
- **Data path:** or_lsu_rdata is held until the next load completes. The unit does no byte lane shifting or extension; memory performs both.

Decomposition:
- **header.vh additions:**
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - Cause codes CAUSE_ILLEGAL=2, CAUSE_LOAD_MISALIGNED=4, CAUSE_LOAD_FAULT=5, CAUSE_STORE_MISALIGNED=6, CAUSE_STORE_FAULT=7.
  - LSU state encodings.
- **Sub-module:** lsu_align_check, combinational.
  - Inputs: addr[1:0], funct3, is_store.
  - Outputs: misaligned, illegal.

Test Plan:
- LW addr 0x0000_0010, memory word 0xDEAD_BEEF, combinational ack -> or_mem_req at N+1 with read_write=1; done at N+2; rdata 0xDEAD_BEEF; rd_we=1 for rd=5.
- SB addr 0x0000_0013, wdata 0x0000_00A5 -> req with funct3 000 and read_write=0; done pulse with rd_we=0; a following LBU of 0x13 returns 0x0000_00A5.
- LH addr 0x0000_0021 -> no req ever; trap at N+1 with cause 4, mtval 0x21. SW addr 0x22 -> trap cause 6, mtval 0x22.
- Load funct3 011 -> trap cause 2, mtval 0, no req.
- Ack held low, TIMEOUT_CYCLES=16 -> req high for exactly 16 cycles; then trap cause 5 (load) or 7 (store); req low afterwards.
- Flush on a load in REQ -> req drops next cycle, no pulse. Flush on a store in REQ -> store completes, no done. i_rst_n low mid-REQ -> req drops the same cycle and all outputs go to 0.
